// File: rtl/freq_pkg.sv
// Shared types and default constants for the square-wave frequency detector.
package freq_pkg;

   typedef enum logic [1:0] {
      WAIT_RISE = 2'd0,
      HIGH      = 2'd1,
      LOW       = 2'd2
   } state_e;

   localparam int unsigned BASE    = 4;
   localparam int unsigned TOL     = 1;
   localparam int unsigned LOCK_N  = 2;
   localparam int unsigned TIMEOUT = 256;
   localparam int unsigned CW      = 16;

   // Nominal half-period, in clk cycles, produced by select code k.
   function automatic int unsigned half_count(input logic [3:0] k, input int unsigned base);
      return base * ({28'd0, k} + 32'd1);
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a previous-value flop and single-cycle edge detects.
module sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic meta_q, sync_q, prev_q;

   // Reset to 1: a signal already high at reset release is not a fresh rise,
   // so a partial high half-period is never measured.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign q    = sync_q;
   assign rise = sync_q & ~prev_q;
   assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/freq_detector.sv
// Measures high/low half-periods of an async square wave and decodes them
// back to the 4-bit select code of the generator, with lock and timeout.
module freq_detector #(
   parameter int unsigned BASE    = freq_pkg::BASE,
   parameter int unsigned TOL     = freq_pkg::TOL,
   parameter int unsigned LOCK_N  = freq_pkg::LOCK_N,
   parameter int unsigned CW      = freq_pkg::CW,
   parameter int unsigned TIMEOUT = freq_pkg::TIMEOUT
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          enable,
   input  logic          sig_in,
   output logic [3:0]    code,
   output logic          code_valid,
   output logic [CW-1:0] period,
   output logic          locked,
   output logic          err,
   output logic          no_signal
);

   import freq_pkg::*;

   localparam int CNT_W = $clog2(LOCK_N + 1);
   localparam int GAP_W = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   logic sig_sync, rise, fall;

   sync_edge u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (sig_in),
      .q       (sig_sync),
      .rise    (rise),
      .fall    (fall)
   );

   state_e           state_q, state_d;
   logic [CW-1:0]    hi_q, hi_d, lo_q, lo_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
   logic [3:0]       code_q, code_d;
   logic [CW-1:0]    period_q, period_d;
   logic             code_valid_q, code_valid_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic             no_signal_q, no_signal_d;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
      return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   endfunction

   function automatic logic within_tol(input logic [CW-1:0] cnt, input int unsigned half);
      int unsigned c, diff;
      c    = 32'(cnt);
      diff = (c >= half) ? (c - half) : (half - c);
      return diff <= TOL;
   endfunction

   logic          match_found;
   logic [3:0]    match_k;
   logic [CW:0]   sum_full;
   logic [CW-1:0] sum_sat;

   // Scanning downward lets the lowest matching code overwrite higher ones.
   always_comb begin
      match_found = 1'b0;
      match_k     = 4'd0;
      for (int k = 15; k >= 0; k--) begin
         if (within_tol(hi_q, half_count(4'(k), BASE)) &&
             within_tol(lo_q, half_count(4'(k), BASE))) begin
            match_found = 1'b1;
            match_k     = 4'(k);
         end
      end
      sum_full = {1'b0, hi_q} + {1'b0, lo_q};
      sum_sat  = sum_full[CW] ? CNT_MAX : sum_full[CW-1:0];
   end

   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      gap_d        = gap_q;
      match_cnt_d  = match_cnt_q;
      code_d       = code_q;
      period_d     = period_q;
      code_valid_d = 1'b0;
      err_d        = 1'b0;
      no_signal_d  = no_signal_q;

      if (!enable) begin
         state_d     = WAIT_RISE;
         hi_d        = '0;
         lo_d        = '0;
         gap_d       = '0;
         match_cnt_d = '0;
         no_signal_d = 1'b0;
      end else begin
         if (rise || fall) begin
            gap_d = '0;
         end else if (gap_q != GAP_W'(TIMEOUT)) begin
            gap_d = gap_q + 1'b1;
         end

         if (rise) begin
            no_signal_d = 1'b0;
         end

         case (state_q)
            WAIT_RISE: begin
               if (rise) begin
                  hi_d    = CW'(1);
                  state_d = HIGH;
               end
            end
            HIGH: begin
               if (!sig_sync) begin
                  lo_d    = CW'(1);
                  state_d = LOW;
               end else begin
                  hi_d = sat_inc(hi_q);
               end
            end
            LOW: begin
               if (rise) begin
                  period_d = sum_sat;
                  if (match_found) begin
                     code_d       = match_k;
                     code_valid_d = 1'b1;
                     if (match_k == code_q) begin
                        if (match_cnt_q != CNT_W'(LOCK_N)) begin
                           match_cnt_d = match_cnt_q + 1'b1;
                        end
                     end else begin
                        match_cnt_d = CNT_W'(1);
                     end
                  end else begin
                     err_d       = 1'b1;
                     match_cnt_d = '0;
                  end
                  hi_d    = CW'(1);
                  state_d = HIGH;
               end else begin
                  lo_d = sat_inc(lo_q);
               end
            end
            default: state_d = WAIT_RISE;
         endcase

         // An edge in the same cycle keeps the counter from ever reaching TIMEOUT.
         if (!rise && !fall && gap_q == GAP_W'(TIMEOUT - 1)) begin
            no_signal_d = 1'b1;
            match_cnt_d = '0;
            state_d     = WAIT_RISE;
         end
      end

      locked_d = (match_cnt_d == CNT_W'(LOCK_N));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= WAIT_RISE;
         hi_q         <= '0;
         lo_q         <= '0;
         gap_q        <= '0;
         match_cnt_q  <= '0;
         code_q       <= '0;
         period_q     <= '0;
         code_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         err_q        <= 1'b0;
         no_signal_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         gap_q        <= gap_d;
         match_cnt_q  <= match_cnt_d;
         code_q       <= code_d;
         period_q     <= period_d;
         code_valid_q <= code_valid_d;
         locked_q     <= locked_d;
         err_q        <= err_d;
         no_signal_q  <= no_signal_d;
      end
   end

   assign code       = code_q;
   assign code_valid = code_valid_q;
   assign period     = period_q;
   assign locked     = locked_q;
   assign err        = err_q;
   assign no_signal  = no_signal_q;

endmodule

// File: tb/tb_freq_detector.sv
// Scoreboard bench for freq_detector: a reference decoder pushes the expected
// result of each completed period, a negedge monitor pops it on every pulse.
module tb_freq_detector;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        sig_in;
   logic [3:0]  code;
   logic        code_valid;
   logic [15:0] period;
   logic        locked;
   logic        err;
   logic        no_signal;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        is_err;
      logic [3:0]  code;
      logic [15:0] period;
      logic        locked;
   } exp_t;

   exp_t sb_q[$];

   logic [3:0] m_code;
   int         m_count;
   bit         pend_valid;
   int         pend_hi, pend_lo;

   always #5 clk = ~clk;

   freq_detector dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .sig_in     (sig_in),
      .code       (code),
      .code_valid (code_valid),
      .period     (period),
      .locked     (locked),
      .err        (err),
      .no_signal  (no_signal)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference decoder: BASE=4, TOL=1, LOCK_N=2, lowest matching code wins.
   task automatic model_eval(input int hi, input int lo);
      exp_t e;
      int   found;
      found = -1;
      for (int k = 0; k < 16; k++) begin
         int h;
         h = 4 * (k + 1);
         if (found < 0 && (hi - h) <= 1 && (h - hi) <= 1 && (lo - h) <= 1 && (h - lo) <= 1)
            found = k;
      end
      e.period = 16'(hi + lo);
      if (found < 0) begin
         m_count  = 0;
         e.is_err = 1'b1;
         e.code   = m_code;
         e.locked = 1'b0;
      end else begin
         if (4'(found) == m_code) m_count = (m_count >= 2) ? 2 : m_count + 1;
         else m_count = 1;
         m_code   = 4'(found);
         e.is_err = 1'b0;
         e.code   = m_code;
         e.locked = (m_count == 2);
      end
      sb_q.push_back(e);
   endtask

   // One full period; its rise closes out the previously driven period.
   task automatic applyStimulus(input int hi, input int lo);
      sig_in = 1'b1;
      if (pend_valid) model_eval(pend_hi, pend_lo);
      wait_cycles(hi);
      sig_in = 1'b0;
      wait_cycles(lo);
      pend_hi    = hi;
      pend_lo    = lo;
      pend_valid = 1'b1;
   endtask

   always @(negedge clk) begin
      if (code_valid || err) begin
         exp_t e;
         checkOutput("sb_pending", 32'(sb_q.size() > 0), 1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput("sb_err", 32'(err), 32'(e.is_err));
            checkOutput("sb_code_valid", 32'(code_valid), 32'(!e.is_err));
            checkOutput("sb_code", 32'(code), 32'(e.code));
            checkOutput("sb_period", 32'(period), 32'(e.period));
            checkOutput("sb_locked", 32'(locked), 32'(e.locked));
         end
      end
   end

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_code"}, 32'(code), 0);
      checkOutput({tag, "_code_valid"}, 32'(code_valid), 0);
      checkOutput({tag, "_period"}, 32'(period), 0);
      checkOutput({tag, "_locked"}, 32'(locked), 0);
      checkOutput({tag, "_err"}, 32'(err), 0);
      checkOutput({tag, "_no_signal"}, 32'(no_signal), 0);
   endtask

   initial begin
      int n;
      m_code     = 4'd0;
      m_count    = 0;
      pend_valid = 1'b0;
      reset_n    = 1'b0;
      enable     = 1'b1;
      sig_in     = 1'b0;
      wait_cycles(3);
      check_all_zero("reset");
      reset_n = 1'b1;
      wait_cycles(5);

      $display("[TB] test 1: 12-cycle halves");
      repeat (5) applyStimulus(12, 12);
      $display("[TB] test 2: hi=8 lo=12");
      repeat (3) applyStimulus(8, 12);
      $display("[TB] test 5: jitter");
      applyStimulus(13, 11);
      applyStimulus(11, 13);
      applyStimulus(14, 12);
      repeat (3) applyStimulus(12, 12);
      $display("[TB] test 4: code change to 24-cycle halves");
      repeat (3) applyStimulus(24, 24);
      repeat (3) applyStimulus(12, 12);

      $display("[TB] test 3: timeout");
      sig_in = 1'b1;
      model_eval(pend_hi, pend_lo);
      wait_cycles(12);
      sig_in = 1'b0;
      n = 0;
      while (n < 400 && !no_signal) begin
         wait_cycles(1);
         n++;
         if (n == 100) checkOutput("locked_before_timeout", 32'(locked), 1);
      end
      checkOutput("timeout_cycles", 32'(n), 259);
      checkOutput("timeout_locked", 32'(locked), 0);
      m_count    = 0;
      pend_valid = 1'b0;
      sig_in     = 1'b1;
      wait_cycles(3);
      checkOutput("no_signal_cleared", 32'(no_signal), 0);
      wait_cycles(9);
      sig_in = 1'b0;
      wait_cycles(12);
      pend_hi    = 12;
      pend_lo    = 12;
      pend_valid = 1'b1;
      repeat (2) applyStimulus(12, 12);

      $display("[TB] test 6: reset mid-HIGH");
      sig_in = 1'b1;
      model_eval(pend_hi, pend_lo);
      wait_cycles(5);
      reset_n = 1'b0;
      #1;
      check_all_zero("midreset");
      m_code     = 4'd0;
      m_count    = 0;
      pend_valid = 1'b0;
      wait_cycles(2);
      reset_n = 1'b1;
      wait_cycles(5);
      sig_in = 1'b0;
      wait_cycles(12);
      repeat (3) applyStimulus(12, 12);

      $display("[TB] test 6b: enable low mid-HIGH");
      sig_in = 1'b1;
      model_eval(pend_hi, pend_lo);
      wait_cycles(5);
      enable = 1'b0;
      wait_cycles(1);
      checkOutput("disable_locked", 32'(locked), 0);
      checkOutput("disable_code", 32'(code), 2);
      checkOutput("disable_no_signal", 32'(no_signal), 0);
      m_count    = 0;
      pend_valid = 1'b0;
      wait_cycles(6);
      sig_in = 1'b0;
      wait_cycles(6);
      enable = 1'b1;
      wait_cycles(6);
      repeat (3) applyStimulus(12, 12);

      wait_cycles(10);
      checkOutput("sb_drained", 32'(sb_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/freq_detector.md
Name: freq_detector

Overview:
- Receive-side counterpart of the select-driven square-wave generator (programmable divider plus toggle flop).
- Samples an asynchronous square wave and measures its high and low half-periods in clk cycles.
- Decodes the measurement back to the 4-bit select code that would produce it and reports lock once the code is stable.
- Used for loopback self-test of the generator and for recovering a select code sent over a single wire.

Parameters:
- BASE, 4: half-period unit. Code k corresponds to a half-period of HALF(k) = BASE*(k+1) clk cycles.
- TOL, 1: allowed deviation, in cycles, on each half-period. Must satisfy 2*TOL < BASE.
- LOCK_N, 2: number of consecutive matching periods with the same code required to assert locked.
- CW, 16: width of the half-period counters and of the period output.
- TIMEOUT, 256: number of clk cycles with no edge after which no_signal is declared. Must exceed 2*HALF(15).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  measurement enable. Low synchronously clears measurement state.
- sig_in  input  1  asynchronous square wave under measurement.
- code  output  4  last matched select code.
- code_valid  output  1  one-cycle pulse on each accepted period.
- period  output  CW  hi_cnt+lo_cnt of the last evaluated period, saturating.
- locked  output  1  high when LOCK_N consecutive matches of the same code have been seen.
- err  output  1  one-cycle pulse when an evaluated period matches no code.
- no_signal  output  1  high when no edge has been seen for TIMEOUT cycles.

Behaviour:
- Reset (reset_n=0, asynchronous): code=0, code_valid=0, period=0, locked=0, err=0, no_signal=0. State=WAIT_RISE, all counters 0.
- Input path: 2-flop synchronizer, then a registered previous-value flop. rise/fall are single-cycle detects on the synchronized signal. The fixed latency is 3 clk cycles and cancels out of all measurements.
- hi_cnt is the number of cycles from the rise detect up to (excluding) the fall detect; lo_cnt is defined likewise from fall to rise. A generator that toggles every N cycles therefore measures hi=lo=N exactly. Both counters saturate at 2^CW-1.
- FSM transitions:
  - WAIT_RISE: ignores everything until rise. On rise, hi_cnt=1 and the FSM goes to HIGH.
  - HIGH: hi_cnt increments each cycle. On fall, lo_cnt=1 and the FSM goes to LOW.
  - LOW: lo_cnt increments each cycle. On rise, the period is evaluated, hi_cnt=1, and the FSM goes to HIGH, so periods are measured back to back with no gap.
- Evaluation, registered and visible the cycle after rise:
  - period is always updated to hi_cnt+lo_cnt, saturating.
  - The match is the lowest k in 0..15 with |hi_cnt-HALF(k)|<=TOL and |lo_cnt-HALF(k)|<=TOL.
  - On a match: code=k and code_valid pulses for 1 cycle.
  - On no match: err pulses for 1 cycle, code holds, locked clears, and the match count resets to 0.
- Lock counter:
  - A match with k equal to the current code increments the count, saturating at LOCK_N.
  - A match with a different k sets the count to 1 and clears locked.
  - locked = (count == LOCK_N).
- Timeout: an edge-gap counter resets on every rise or fall.
  - When it reaches TIMEOUT: no_signal=1, locked=0, count=0, state=WAIT_RISE, and the counter holds.
  - no_signal clears on the next rise.
  - If rise and timeout occur in the same cycle, the edge wins.
- enable=0: state=WAIT_RISE and all counters cleared. locked=0, no_signal=0, no pulses. code and period hold. The synchronizer keeps running.
- Reset asserted mid-period: outputs clear immediately. After release, the partial period is discarded and measurement resumes from the first full rise.

Decomposition:
- Package freq_pkg holds:
  - FSM state encoding (WAIT_RISE, HIGH, LOW);
  - function half_count(k);
  - default constants BASE, TOL, LOCK_N, TIMEOUT.
- Sub-module sync_edge holds the 2-flop synchronizer and rise/fall detect, with ports clk, reset_n, d, q, rise, fall.

Test Plan:
- All tests use default parameters.
- 1: sig_in toggles every 12 cycles, 4 periods -> code_valid pulse each period, code=2, period=24, locked=1 from the second evaluation, err never pulses.
- 2: hi=8, lo=12 repeated -> err pulse each period, code unchanged, locked=0, code_valid never pulses.
- 3: Lock on code 2, then hold sig_in low -> no_signal=1 and locked=0 exactly 256 cycles after the last fall; the next rise clears no_signal.
- 4: Lock on code 2, then switch to 24-cycle halves -> locked drops at the first new evaluation with code=5, and re-asserts at the second.
- 5: Jitter case, hi=13/lo=11 then hi=11/lo=13 -> both decode to code=2 and locked=1. A hi=14 period -> err.
- 6: Pulse reset_n low mid-HIGH -> all outputs 0 within the same cycle, with no code_valid for the truncated period. Repeat with enable=0 -> code holds and locked=0.
